// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
// The optional grant statistics are enabled with the macro DATA_MEM_ARB_STATS_EN.
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int COUNT_WIDTH = 16;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Round-robin winner selection: the search starts at the core after lastWinner
// and wraps around, so the most recent winner has the lowest priority.
module rr_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int CORE_COUNT = 4
) (
    input  logic [CORE_COUNT-1:0]         req,
    input  logic [$clog2(CORE_COUNT)-1:0] lastWinner,
    output logic [$clog2(CORE_COUNT)-1:0] grantIdx,
    output logic                          grantValid
);

    localparam int IDX_WIDTH = $clog2(CORE_COUNT);

    logic [IDX_WIDTH-1:0] cand;

    // Walk the candidates from the farthest offset down to the nearest one so the
    // first requester after lastWinner is the last to overwrite the result.
    always_comb begin
        grantIdx   = '0;
        grantValid = 1'b0;
        cand       = '0;
        for (int offset = CORE_COUNT; offset >= 1; offset--) begin
            cand = IDX_WIDTH'((int'(lastWinner) + offset) % CORE_COUNT);
            if (req[cand]) begin
                grantIdx   = cand;
                grantValid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one synchronous single-port RAM between CORE_COUNT cores.
// Each access walks IDLE -> ISSUE -> (WAIT, reads only) -> RESP.
// Defining DATA_MEM_ARB_STATS_EN adds the grantCount output with saturating
// per-core grant counters.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter  int CORE_COUNT = 4,
    parameter  int WIDTH      = 12,
    parameter  int DEPTH      = 4096,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CORE_COUNT-1:0]            coreReq,
    input  logic [CORE_COUNT-1:0]            coreWrEn,
    input  logic [CORE_COUNT*ADDR_WIDTH-1:0] coreAddr,
    input  logic [CORE_COUNT*WIDTH-1:0]      coreDataIn,
    output logic [CORE_COUNT-1:0]            coreDone,
    output logic [WIDTH-1:0]                 coreDataOut,
    output logic                             ramWrEn,
    output logic [ADDR_WIDTH-1:0]            ramAddr,
    output logic [WIDTH-1:0]                 ramDataIn,
    input  logic [WIDTH-1:0]                 ramDataOut
`ifdef DATA_MEM_ARB_STATS_EN
    ,
    output logic [CORE_COUNT*COUNT_WIDTH-1:0] grantCount
`endif
);

    localparam int IDX_WIDTH = $clog2(CORE_COUNT);

    state_t                state;
    state_t                state_next;
    logic [IDX_WIDTH-1:0]  winner_q;
    logic [IDX_WIDTH-1:0]  last_winner_q;
    logic [IDX_WIDTH-1:0]  grant_idx;
    logic                  grant_valid;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [WIDTH-1:0]      ram_data_q;
    logic                  ram_wr_en_q;
    logic [WIDTH-1:0]      data_out_q;
    logic [CORE_COUNT-1:0] done_vec;

    rr_arbiter #(
        .CORE_COUNT(CORE_COUNT)
    ) u_rr_arbiter (
        .req       (coreReq),
        .lastWinner(last_winner_q),
        .grantIdx  (grant_idx),
        .grantValid(grant_valid)
    );

    // State register; reset always returns to IDLE and abandons any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing and the completion pulse for the latched winner.
    always_comb begin
        state_next = state;
        done_vec   = '0;
        case (state)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   state_next = ram_wr_en_q ? RESP : WAIT;
            WAIT:    state_next = RESP;
            RESP: begin
                state_next         = IDLE;
                done_vec[winner_q] = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the winning request straight into the RAM-side registers so they are
    // valid for the whole ISSUE cycle, and capture read data one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            winner_q      <= '0;
            last_winner_q <= IDX_WIDTH'(CORE_COUNT - 1);
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            ram_wr_en_q   <= 1'b0;
            data_out_q    <= '0;
        end else begin
            ram_wr_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        winner_q      <= grant_idx;
                        last_winner_q <= grant_idx;
                        ram_addr_q    <= coreAddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        ram_wr_en_q   <= coreWrEn[grant_idx];
                        if (coreWrEn[grant_idx]) begin
                            ram_data_q <= coreDataIn[grant_idx*WIDTH +: WIDTH];
                        end
                    end
                end
                WAIT:    data_out_q <= ramDataOut;
                default: ;
            endcase
        end
    end

    // A reset arriving while a write is presented must stop the RAM from taking
    // it at that same edge, and a reset during RESP must suppress the pulse, so
    // both strobes are qualified by rst.
    assign ramWrEn     = ram_wr_en_q & ~rst;
    assign coreDone    = done_vec & {CORE_COUNT{~rst}};
    assign ramAddr     = ram_addr_q;
    assign ramDataIn   = ram_data_q;
    assign coreDataOut = data_out_q;

`ifdef DATA_MEM_ARB_STATS_EN
    logic [CORE_COUNT*COUNT_WIDTH-1:0] grant_count_q;

    // Count completed grants per core, holding at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count_q <= '0;
        end else begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                if (coreDone[i] && (grant_count_q[i*COUNT_WIDTH +: COUNT_WIDTH] != COUNT_MAX)) begin
                    grant_count_q[i*COUNT_WIDTH +: COUNT_WIDTH] <=
                        grant_count_q[i*COUNT_WIDTH +: COUNT_WIDTH] + 1'b1;
                end
            end
        end
    end

    assign grantCount = grant_count_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural synchronous RAM.
// Build with DATA_MEM_ARB_STATS_EN defined to also exercise grantCount.
module tb_data_mem_arbiter;

    localparam int CORES = 4;
    localparam int W     = 12;
    localparam int AW    = 12;

    logic               clk;
    logic               rst;
    logic [CORES-1:0]   coreReq;
    logic [CORES-1:0]   coreWrEn;
    logic [CORES*AW-1:0] coreAddr;
    logic [CORES*W-1:0] coreDataIn;
    logic [CORES-1:0]   coreDone;
    logic [W-1:0]       coreDataOut;
    logic               ramWrEn;
    logic [AW-1:0]      ramAddr;
    logic [W-1:0]       ramDataIn;
    logic [W-1:0]       ramDataOut;
`ifdef DATA_MEM_ARB_STATS_EN
    logic [CORES*16-1:0] grantCount;
`endif

    int compared;
    int mismatched;

    logic [W-1:0] mem [1 << AW];
    logic         preload;

    data_mem_arbiter #(
        .CORE_COUNT(CORES),
        .WIDTH     (W),
        .DEPTH     (1 << AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coreReq    (coreReq),
        .coreWrEn   (coreWrEn),
        .coreAddr   (coreAddr),
        .coreDataIn (coreDataIn),
        .coreDone   (coreDone),
        .coreDataOut(coreDataOut),
        .ramWrEn    (ramWrEn),
        .ramAddr    (ramAddr),
        .ramDataIn  (ramDataIn),
        .ramDataOut (ramDataOut)
`ifdef DATA_MEM_ARB_STATS_EN
        ,
        .grantCount (grantCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the address edge.
    always @(posedge clk) begin
        if (preload) begin
            mem[12'hFFF] <= 12'h123;
        end else if (ramWrEn) begin
            mem[ramAddr] <= ramDataIn;
        end
        ramDataOut <= mem[ramAddr];
    end

    typedef struct {
        int           core;
        logic         wr;
        logic [AW-1:0] addr;
        logic [W-1:0] data;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [10];

    // One comparison: counts it and reports a mismatch on a single FAIL line.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present a single-core request at the falling edge; all other cores idle.
    task automatic applyStimulus(input int core, input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] data);
        @(negedge clk);
        coreReq                   = '0;
        coreWrEn[core]            = wr;
        coreAddr[core*AW +: AW]   = addr;
        coreDataIn[core*W +: W]   = data;
        coreReq[core]             = 1'b1;
    endtask

    // Wait (bounded) until some coreDone bit is observed just after a rising edge.
    task automatic waitDone(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (coreDone != '0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Run one isolated request; latency counts the IDLE cycle in which it is sampled.
    task automatic runVector(input vec_t v);
        int lat;
        bit seen;
        applyStimulus(v.core, v.wr, v.addr, v.data);
        lat  = 1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (c == 0) begin
                checkOutput("issue_addr", 64'(ramAddr), 64'(v.addr));
                checkOutput("issue_wren", 64'(ramWrEn), 64'(v.wr));
                if (v.wr) checkOutput("issue_data", 64'(ramDataIn), 64'(v.data));
            end
            if (c == 1) checkOutput("wren_after_issue", 64'(ramWrEn), 64'd0);
            if (coreDone != '0) seen = 1'b1;
        end
        checkOutput("done_seen", 64'(seen), 64'd1);
        checkOutput("latency", 64'(lat), v.wr ? 64'd3 : 64'd4);
        checkOutput("done_onehot", 64'(coreDone), 64'(1 << v.core));
        if (!v.wr) checkOutput("read_data", 64'(coreDataOut), 64'(v.exp));
        @(negedge clk);
        coreReq = '0;
        @(posedge clk);
        #1;
        checkOutput("done_pulse_len", 64'(coreDone), 64'd0);
    endtask

    logic [W-1:0] fair_data [CORES];

    initial begin
        bit ok;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        preload    = 1'b1;
        coreReq    = '0;
        coreWrEn   = '0;
        coreAddr   = '0;
        coreDataIn = '0;

        vecs[0] = '{core: 2, wr: 1'b1, addr: 12'h005, data: 12'hABC, exp: 12'h000};
        vecs[1] = '{core: 0, wr: 1'b0, addr: 12'h005, data: 12'h000, exp: 12'hABC};
        vecs[2] = '{core: 1, wr: 1'b0, addr: 12'hFFF, data: 12'h000, exp: 12'h123};
        vecs[3] = '{core: 3, wr: 1'b1, addr: 12'hFFF, data: 12'h7E5, exp: 12'h000};
        vecs[4] = '{core: 0, wr: 1'b0, addr: 12'hFFF, data: 12'h000, exp: 12'h7E5};
        vecs[5] = '{core: 1, wr: 1'b1, addr: 12'h000, data: 12'h001, exp: 12'h000};
        vecs[6] = '{core: 2, wr: 1'b0, addr: 12'h000, data: 12'h000, exp: 12'h001};
        vecs[7] = '{core: 3, wr: 1'b0, addr: 12'h005, data: 12'h000, exp: 12'hABC};
        vecs[8] = '{core: 0, wr: 1'b1, addr: 12'h0FE, data: 12'hFFF, exp: 12'h000};
        vecs[9] = '{core: 1, wr: 1'b0, addr: 12'h0FE, data: 12'h000, exp: 12'hFFF};

        // Reset values, sampled while rst is still high.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_done", 64'(coreDone), 64'd0);
        checkOutput("rst_dataout", 64'(coreDataOut), 64'd0);
        checkOutput("rst_wren", 64'(ramWrEn), 64'd0);
        checkOutput("rst_addr", 64'(ramAddr), 64'd0);
        checkOutput("rst_datain", 64'(ramDataIn), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        preload = 1'b0;

        for (int i = 0; i < 10; i++) runVector(vecs[i]);

        // Fairness: all cores read continuously; order must be 0,1,2,3 three times.
        doReset(2);
        fair_data[0] = 12'hABC;
        fair_data[1] = 12'h7E5;
        fair_data[2] = 12'h001;
        fair_data[3] = 12'hABC;
        @(negedge clk);
        coreWrEn = '0;
        coreAddr = {12'h005, 12'h000, 12'hFFF, 12'h005};
        coreReq  = 4'hF;
        for (int g = 0; g < 12; g++) begin
            waitDone(ok);
            checkOutput("fair_done_seen", 64'(ok), 64'd1);
            checkOutput("fair_order", 64'(coreDone), 64'(1 << (g % CORES)));
            checkOutput("fair_data", 64'(coreDataOut), 64'(fair_data[g % CORES]));
        end
        @(negedge clk);
        coreReq = '0;
        @(posedge clk);

`ifdef DATA_MEM_ARB_STATS_EN
        for (int i = 0; i < CORES; i++) begin
            checkOutput("stats_count", 64'(grantCount[i*16 +: 16]), 64'd3);
        end
        @(negedge clk);
        force dut.grant_count_q = '1;
        @(negedge clk);
        release dut.grant_count_q;
        runVector('{core: 1, wr: 1'b0, addr: 12'hFFF, data: 12'h000, exp: 12'h7E5});
        checkOutput("stats_saturate", 64'(grantCount[16 +: 16]), 64'hFFFF);
`endif

        // A late request from core 3 while core 0 is mid-read must wait its turn,
        // and a changed address from core 0 after the grant must not leak in.
        applyStimulus(0, 1'b0, 12'hFFF, 12'h000);
        @(posedge clk);
        #1;
        @(negedge clk);
        coreAddr[0 +: AW] = 12'h000;
        @(posedge clk);
        #1;
        @(negedge clk);
        coreWrEn[3]         = 1'b0;
        coreAddr[3*AW +: AW] = 12'h000;
        coreReq[3]          = 1'b1;
        waitDone(ok);
        checkOutput("ignore_first_done", 64'(coreDone), 64'b0001);
        checkOutput("ignore_first_data", 64'(coreDataOut), 64'h7E5);
        @(negedge clk);
        coreReq[0] = 1'b0;
        waitDone(ok);
        checkOutput("ignore_second_done", 64'(coreDone), 64'b1000);
        checkOutput("ignore_second_data", 64'(coreDataOut), 64'h001);
        @(negedge clk);
        coreReq = '0;
        @(posedge clk);

        // Reset held two cycles during a read's WAIT cycle: no completion at all.
        applyStimulus(1, 1'b0, 12'hFFF, 12'h000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_read_nodone", 64'(coreDone), 64'd0);
        end
        @(negedge clk);
        rst     = 1'b0;
        coreReq = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_nodone", 64'(coreDone), 64'd0);
        end
        checkOutput("rst_read_mem_fff", 64'(mem[12'hFFF]), 64'h7E5);
        checkOutput("rst_read_mem_005", 64'(mem[12'h005]), 64'hABC);
        runVector('{core: 0, wr: 1'b1, addr: 12'h010, data: 12'h555, exp: 12'h000});

        // Reset arriving during a write's ISSUE cycle must keep the RAM untouched.
        applyStimulus(2, 1'b1, 12'h000, 12'h0FF);
        @(posedge clk);
        #1;
        checkOutput("abort_issue_wren", 64'(ramWrEn), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_wren_gated", 64'(ramWrEn), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("abort_nodone", 64'(coreDone), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        coreReq = '0;
        @(posedge clk);
        #1;
        checkOutput("abort_mem", 64'(mem[12'h000]), 64'h001);
        runVector('{core: 2, wr: 1'b0, addr: 12'h000, data: 12'h000, exp: 12'h001});
        runVector('{core: 3, wr: 1'b0, addr: 12'h010, data: 12'h000, exp: 12'h555});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global bound so a stuck run still terminates with a report.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
